// File: rtl/div5_arbiter.sv
// div5_arbiter: four requesters share one combinational divide-by-5 datapath
// through a round-robin arbiter. The result sits in a one-entry registered
// output stage (EMPTY/FULL) with valid/ready handshaking on both sides.
// Optional feature: define DIV5_ARBITER_CHECK_EN to build the sticky chk_err
// self-check (5*Q+R == X and R <= 4 on every load); otherwise chk_err is 0.

// Combinational 16-bit divide-by-5: restoring long division, one quotient
// bit per dividend bit. Bits 15:14 of the quotient are always zero because
// x[15:14] <= 3 < 5, so the division starts with those two bits as the
// partial remainder and only 14 quotient bits are produced.
module div_16_5 (
  input  logic [15:0] x,
  output logic [13:0] q,
  output logic [2:0]  r
);

  logic [2:0] rem;
  logic [3:0] part;

  // Shift in one dividend bit at a time; subtract 5 whenever it fits.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    q    = '0;
    rem  = {1'b0, x[15:14]};
    part = '0;
    for (int i = 13; i >= 0; i--) begin
      part = {rem, x[i]};
      if (part >= 4'd5) begin
        q[i] = 1'b1;
        rem  = 3'(part - 4'd5);
      end else begin
        rem  = part[2:0];
      end
    end
    r = rem;
  end

endmodule

module div5_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_X,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_id,
  output logic [13:0]          Q,
  output logic [2:0]           R,
  input  logic                 rsp_ready,
  output logic                 chk_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  ptr;
  logic [1:0]  grant_idx;
  logic [1:0]  search_idx;
  logic        grant_any;
  logic        can_load;
  logic        transfer;
  logic [15:0] sel_x;
  logic [13:0] dp_q;
  logic [2:0]  dp_r;

  // Round-robin search: first valid requester at ptr, ptr+1, ... (mod 4).
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = ptr;
    search_idx = ptr;
    for (int k = 0; k < NREQ; k++) begin
      search_idx = ptr + 2'(k);
      if (!grant_any && req_valid[search_idx]) begin
        grant_any = 1'b1;
        grant_idx = search_idx;
      end
    end
  end

  // The output stage can take a new result when empty or draining this cycle.
  assign can_load = (state == EMPTY) || rsp_ready;

  // Accept is one-hot on the winner, and held off during reset or when full and stalled.
  always_comb begin
    req_ready = '0;
    if (!rst && grant_any && can_load) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign transfer = |req_ready;

  // The single shared divider sees the winner's dividend.
  assign sel_x = req_X[16*grant_idx +: 16];

  div_16_5 u_div (
    .x (sel_x),
    .q (dp_q),
    .r (dp_r)
  );

  // Output-stage next state: load on transfer, drain on rsp_ready without a reload.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (transfer)               state_nxt = FULL;
      FULL:    if (rsp_ready && !transfer) state_nxt = EMPTY;
      default:                             state_nxt = EMPTY;
    endcase
  end

  // Output-stage state register; reset discards any held result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  assign rsp_valid = (state == FULL);

  // Capture the result and owner on transfer, and advance the pointer past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= 2'd0;
      rsp_id <= 2'd0;
      Q      <= '0;
      R      <= '0;
    end else if (transfer) begin
      ptr    <= grant_idx + 2'd1;
      rsp_id <= grant_idx;
      Q      <= dp_q;
      R      <= dp_r;
    end
  end

`ifdef DIV5_ARBITER_CHECK_EN
  logic [16:0] recon;
  logic        bad_result;

  // 5*Q + R rebuilt from shifts, widened so the sum cannot wrap.
  assign recon      = {1'b0, dp_q, 2'b00} + {3'b000, dp_q} + {14'd0, dp_r};
  assign bad_result = (recon != {1'b0, sel_x}) || (dp_r > 3'd4);

  // Sticky flag: set the cycle after a bad load, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                          chk_err <= 1'b0;
    else if (transfer && bad_result)  chk_err <= 1'b1;
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_div5_arbiter.sv
// Self-checking bench for div5_arbiter. A behavioural model (pointer as an
// integer, one-slot result holder, / and % for the arithmetic) predicts every
// output; a negedge compare process checks the DUT against it each cycle.
// Directed scenarios add literal expectations, followed by random traffic
// and a full 0..65535 dividend sweep.
module tb_div5_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_x;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [13:0] q_out;
  logic [2:0]  r_out;
  logic        rsp_ready;
  logic        chk_err;

  int checks   = 0;
  int failures = 0;

  div5_arbiter #(.NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_X     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .Q         (q_out),
    .R         (r_out),
    .rsp_ready (rsp_ready),
    .chk_err   (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Winner = valid requester with the smallest forward distance from ptr.
  function automatic int winner(input logic [3:0] v, input int p);
    int best  = -1;
    int bestd = 5;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && ((i - p + 4) % 4) < bestd) begin
        bestd = (i - p + 4) % 4;
        best  = i;
      end
    end
    return best;
  endfunction

  // ---------------- behavioural model ----------------
  bit live    = 0;
  bit m_valid = 0;
  int m_id    = 0;
  int m_q     = 0;
  int m_r     = 0;
  int m_ptr   = 0;

  always @(posedge clk) begin
    int w;
    int xv;
    if (rst) begin
      live    = 1;
      m_valid = 0;
      m_ptr   = 0;
    end else if (live) begin
      w = winner(req_valid, m_ptr);
      if (w >= 0 && (!m_valid || rsp_ready)) begin
        xv      = int'(req_x[16*w +: 16]);
        m_valid = 1;
        m_id    = w;
        m_q     = xv / 5;
        m_r     = xv % 5;
        m_ptr   = (w + 1) % 4;
      end else if (rsp_ready) begin
        m_valid = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int w;
    logic [3:0] er;
    if (live) begin
      w  = winner(req_valid, m_ptr);
      er = 4'b0000;
      if (!rst && w >= 0 && (!m_valid || rsp_ready)) er[w] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(er));
      check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("Q", 32'(q_out), 32'(m_q));
        check("R", 32'(r_out), 32'(m_r));
      end
      check("chk_err", 32'(chk_err), 32'd0);
    end
  end

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic step(input logic r, input logic [3:0] v, input logic [63:0] x, input logic rr);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_x     = x;
    rsp_ready = rr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    step(1'b1, 4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    logic [13:0] exp_q [4];
    logic [2:0]  exp_r [4];
    logic [63:0] rx;
    exp_q = '{14'd0, 14'd1, 14'd13107, 14'd4};
    exp_r = '{3'd4, 3'd0, 3'd0, 3'd3};

    rst = 1'b1; req_valid = 4'b0000; req_x = '0; rsp_ready = 1'b0;

    // Reset state, with requests pending and the consumer ready.
    do_reset();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_Q", 32'(q_out), 32'd0);
    check("rst_R", 32'(r_out), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_chk_err", 32'(chk_err), 32'd0);

    // Single request, X0 = 7 -> Q=1, R=2 one cycle later.
    step(1'b0, 4'b0001, 64'd7, 1'b1);
    check("single_ready", 32'(req_ready), 32'b0001);
    check("single_empty", 32'(rsp_valid), 32'd0);
    step(1'b0, 4'b0000, 64'd0, 1'b1);
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_id", 32'(rsp_id), 32'd0);
    check("single_Q", 32'(q_out), 32'd1);
    check("single_R", 32'(r_out), 32'd2);

    // Round robin over all four, including the X=65535 width corner.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'b1111, {16'd23, 16'd65535, 16'd5, 16'd4}, 1'b1);
      check("rr_ready", 32'(req_ready), 32'(4'b0001 << k));
      if (k > 0) begin
        check("rr_id", 32'(rsp_id), 32'(k - 1));
        check("rr_Q", 32'(q_out), 32'(exp_q[k-1]));
        check("rr_R", 32'(r_out), 32'(exp_r[k-1]));
      end
    end
    step(1'b0, 4'b0000, 64'd0, 1'b1);
    check("rr_id3", 32'(rsp_id), 32'd3);
    check("rr_Q3", 32'(q_out), 32'd4);
    check("rr_R3", 32'(r_out), 32'd3);
    step(1'b0, 4'b0000, 64'd0, 1'b1);
    check("rr_drained", 32'(rsp_valid), 32'd0);

    // Backpressure: hold a result for 3 stalled cycles, then drain and reload.
    do_reset();
    step(1'b0, 4'b0001, 64'd10, 1'b0);
    check("bp_first_ready", 32'(req_ready), 32'b0001);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0100, {16'd0, 16'd42, 16'd0, 16'd0}, 1'b0);
      check("bp_ready_blocked", 32'(req_ready), 32'd0);
      check("bp_hold_id", 32'(rsp_id), 32'd0);
      check("bp_hold_Q", 32'(q_out), 32'd2);
      check("bp_hold_R", 32'(r_out), 32'd0);
    end
    step(1'b0, 4'b0100, {16'd0, 16'd42, 16'd0, 16'd0}, 1'b1);
    check("bp_reload_ready", 32'(req_ready), 32'b0100);
    step(1'b0, 4'b0000, 64'd0, 1'b1);
    check("bp_new_id", 32'(rsp_id), 32'd2);
    check("bp_new_Q", 32'(q_out), 32'd8);
    check("bp_new_R", 32'(r_out), 32'd2);

    // Fairness: requesters 0 and 3 held valid alternate grants.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 4'b1001, {16'd30, 16'd0, 16'd0, 16'd11}, 1'b1);
      check("fair_ready", 32'(req_ready), (k % 2 == 0) ? 32'b0001 : 32'b1000);
    end

    // Reset while FULL with all requesting: result discarded, ptr back to 0.
    do_reset();
    step(1'b0, 4'b1111, 64'h0001_0002_0003_0004, 1'b0);
    check("mid_first_ready", 32'(req_ready), 32'b0001);
    step(1'b0, 4'b1111, 64'h0001_0002_0003_0004, 1'b0);
    check("mid_full", 32'(rsp_valid), 32'd1);
    step(1'b1, 4'b1111, 64'h0001_0002_0003_0004, 1'b0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    step(1'b0, 4'b1111, 64'h0001_0002_0003_0004, 1'b0);
    check("mid_after_valid", 32'(rsp_valid), 32'd0);
    check("mid_after_ready", 32'(req_ready), 32'b0001);
    step(1'b0, 4'b0000, 64'd0, 1'b1);
    check("mid_after_id", 32'(rsp_id), 32'd0);

    // Random traffic: occasional reset, random requests, dividends and backpressure.
    for (int n = 0; n < 2000; n++) begin
      rx = {$urandom, $urandom};
      for (int l = 0; l < 4; l++) begin
        case ($urandom_range(0, 7))
          0:       rx[16*l +: 16] = 16'hFFFF;
          1:       rx[16*l +: 16] = 16'h0000;
          default: ;
        endcase
      end
      step(($urandom_range(0, 63) == 0), 4'($urandom), rx, ($urandom_range(0, 9) < 7));
    end

    // Exhaustive dividend sweep through rotating requesters.
    do_reset();
    for (int x = 0; x < 65536; x++) begin
      step(1'b0, 4'(1 << (x % 4)), {4{16'(x)}}, 1'b1);
    end
    step(1'b0, 4'b0000, 64'd0, 1'b1);
    check("sweep_last_Q", 32'(q_out), 32'd13107);
    check("sweep_last_R", 32'(r_out), 32'd0);
    step(1'b0, 4'b0000, 64'd0, 1'b1);
    check("sweep_chk_err", 32'(chk_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div5_arbiter.md
DIV5_ARBITER -- requirements
Module: div5_arbiter

Interface
REQ-001 The module SHALL have parameter NREQ, default 4, giving the number of requesters; 4 is the only supported value.
REQ-002 The module SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  4  per-requester request valid.
REQ-006 req_X  input  64  dividends, requester i on bits [16*i+15:16*i], unsigned.
REQ-007 req_ready  output  4  per-requester accept, one-hot or zero.
REQ-008 rsp_valid  output  1  registered result valid.
REQ-009 rsp_id  output  2  index of the requester that owns the result.
REQ-010 Q  output  14  quotient floor(X/5).
REQ-011 R  output  3  remainder X mod 5, range 0..4.
REQ-012 rsp_ready  input  1  consumer accepts the result.
REQ-013 chk_err  output  1  sticky self-check failure flag; see Configuration.

Function
REQ-014 The block SHALL share one combinational instance of the 16-bit divide-by-5 datapath (div_16_5) between all requesters.
REQ-015 Arbitration SHALL be round-robin with pointer ptr (2 bits):
- grant = first i with req_valid[i], searching ptr, ptr+1, ... modulo 4.
REQ-016 A transfer SHALL occur on requester i when req_valid[i] & req_ready[i] are high in the same cycle.
REQ-017 After a transfer on requester i, ptr SHALL become (i+1) mod 4; otherwise ptr SHALL hold.
REQ-018 req_ready[i] SHALL equal grant[i] & (~rsp_valid | rsp_ready) and SHALL be combinational.
- req_ready SHALL be all-zero when no req_valid is high.
REQ-019 The output stage SHALL be a two-state FSM:
- EMPTY (rsp_valid=0) -> FULL on a transfer.
- FULL -> EMPTY on rsp_ready with no transfer.
- FULL -> FULL on rsp_ready with a transfer; new result loaded.
- FULL -> FULL with no rsp_ready; result held.
REQ-020 The result SHALL appear on the cycle after the transfer (latency 1). Throughput SHALL be 1 result/cycle while rsp_ready stays high.
REQ-021 On load, Q, R and rsp_id SHALL capture the datapath output for the granted X and the granted index. They SHALL be stable while FULL and rsp_ready is low.
REQ-022 Width rule: X=65535 SHALL give Q=13107, R=0. The 14-bit Q SHALL never overflow.
REQ-023 A requester SHALL be allowed to drop req_valid without a transfer; arbitration re-evaluates every cycle.
REQ-024 Simultaneous drain and load in FULL SHALL lose no result and duplicate none.

Reset
REQ-025 While rst is high at a clock edge: rsp_valid=0, rsp_id=0, Q=0, R=0, ptr=0, chk_err=0, FSM=EMPTY.
REQ-026 req_ready SHALL be all-zero while rst is high.
REQ-027 Reset asserted while FULL SHALL discard the held result, with no rsp_valid on the following cycle.

Configuration
REQ-028 Macro DIV5_ARBITER_CHECK_EN SHALL compile in a self-check:
- On each load, compute 5*Q+R != X or R>4.
- If true, set chk_err on the next cycle; it stays set until rst.
REQ-029 Without DIV5_ARBITER_CHECK_EN, chk_err SHALL be tied to 0 and no check logic SHALL be present. Port list is identical in both builds.

Verification
REQ-030 Reset, single request: reset, then req_valid=0001, X0=7 -> req_ready=0001 in that cycle; next cycle rsp_valid=1, rsp_id=0, Q=1, R=2.
REQ-031 Round-robin: all four valid with rsp_ready=1 and X0..3=4, 5, 65535, 23 -> results in id order 0,1,2,3 on consecutive cycles:
- (Q,R) = (0,4), (1,0), (13107,0), (4,3).
REQ-032 Backpressure: FULL with rsp_ready=0 for 3 cycles and requester 2 valid -> req_ready=0000, Q/R/rsp_id unchanged; on rsp_ready=1 the same cycle loads requester 2.
REQ-033 Fairness: requesters 0 and 3 held valid continuously with rsp_ready=1 -> grants alternate 0,3,0,3; neither waits more than 1 transfer.
REQ-034 Reset mid-operation: rst pulsed while FULL and req_valid=1111 -> next cycle rsp_valid=0, ptr=0; first grant after rst falls goes to requester 0.
REQ-035 Exhaustive: with DIV5_ARBITER_CHECK_EN defined, sweep X=0..65535 through rotating requesters -> every result matches floor(X/5) and X mod 5, and chk_err stays 0.
